// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: fetch stage issuing imem reads at pc and queueing {pc, instr} in order for decode
// Ports:
//   clk, rst_async                      clock, async active-high reset
//   pc, flush -> stall_n                PC register interface (stall_n = fetch accepted)
//   imem_req/addr/gnt/rvalid/rdata      in-order instruction memory read port
//   if_valid/if_ready/if_pc/if_instr    decode handshake, head of queue
module instr_fetch_buffer #(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        rst_async,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        stall_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [31:0] pc_q [DEPTH];
  logic [31:0] instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [AW-1:0] head, tail, fptr;
  logic [CNT_W-1:0] count, pend, discard;
  logic accept, pop, fill, ret;
  // Killed requests still occupy a slot until their data returns, so they count against space.
  assign imem_req  = !rst_async && !flush && ((CNT_W+1)'(count) + (CNT_W+1)'(discard) < (CNT_W+1)'(DEPTH));
  assign imem_addr = pc;
  assign stall_n   = imem_req && imem_gnt;
  assign accept    = stall_n;
  // A return with nothing outstanding is a protocol error and is ignored.
  assign ret       = imem_rvalid && (discard != '0 || pend != '0);
  assign fill      = imem_rvalid && discard == '0 && pend != '0 && !flush;
  assign pop       = if_valid && if_ready && !flush;
  assign if_valid  = filled_q[head];
  assign if_pc     = pc_q[head];
  assign if_instr  = instr_q[head];
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
      filled_q <= '0;
      head     <= '0;
      tail     <= '0;
      fptr     <= '0;
      count    <= '0;
      pend     <= '0;
      discard  <= '0;
    end else if (flush) begin
      filled_q <= '0;
      head     <= '0;
      tail     <= '0;
      fptr     <= '0;
      count    <= '0;
      pend     <= '0;
      discard  <= discard + pend - CNT_W'(ret);
    end else begin
      if (accept) begin
        pc_q[tail] <= pc;
        tail       <= tail + AW'(1);
      end
      if (fill) begin
        instr_q[fptr]  <= imem_rdata;
        filled_q[fptr] <= 1'b1;
        fptr           <= fptr + AW'(1);
      end
      if (pop) begin
        filled_q[head] <= 1'b0;
        head           <= head + AW'(1);
      end
      count <= count + CNT_W'(accept) - CNT_W'(pop);
      pend  <= pend + CNT_W'(accept) - CNT_W'(fill);
      if (imem_rvalid && discard != '0) discard <= discard - CNT_W'(1);
    end
  end
endmodule
